// File: rtl/a2d_chnl_sched.sv
//-----------------------------------------------------------------------------
// a2d_chnl_sched
//   Round-robin scheduler that shares one SPI monarch between four ADC128S
//   channels: left load cell, right load cell, steering pot and battery.
//   Each i_nxt pulse runs one conversion made of two SPI transactions. The
//   first sends the channel command. The second returns that channel's
//   12-bit result, which is stored in the register for the current channel.
//
// Ports
//   i_clk        system clock
//   i_rst_n      async active-low reset
//   i_nxt        request next conversion (1-clk pulse)
//   i_done       spi_mnrch transaction complete (1-clk pulse)
//   i_rd_data    spi_mnrch received word (only [11:0] is kept)
//   o_wrt        start spi_mnrch transaction (1-clk pulse)
//   o_cmd        word for spi_mnrch to send (registered)
//   o_lft_ld     latest left load cell result
//   o_rght_ld    latest right load cell result
//   o_steer_pot  latest steering pot result
//   o_batt       latest battery result
//   o_busy       conversion in progress
//   o_conv_done  1-clk pulse, a result register was just updated
//
// Build option
//   A2D_NXT_QUEUE_EN : when defined, one i_nxt arriving while busy is
//   remembered. The scheduler then chains straight into the next channel's
//   conversion instead of dropping the request.
//-----------------------------------------------------------------------------
`timescale 1ns/1ps

module a2d_chnl_sched #(
    parameter logic [2:0] CH_LFT   = 3'd0,
    parameter logic [2:0] CH_RGHT  = 3'd4,
    parameter logic [2:0] CH_STEER = 3'd5,
    parameter logic [2:0] CH_BATT  = 3'd6,
    parameter int         GAP_CYC  = 2
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_nxt,
    input  logic        i_done,
    input  logic [15:0] i_rd_data,
    output logic        o_wrt,
    output logic [15:0] o_cmd,
    output logic [11:0] o_lft_ld,
    output logic [11:0] o_rght_ld,
    output logic [11:0] o_steer_pot,
    output logic [11:0] o_batt,
    output logic        o_busy,
    output logic        o_conv_done
);

    localparam int              GW       = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
    localparam logic [GW-1:0]   GAP_LAST = GW'(GAP_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_WAIT1,
        S_GAP,
        S_RD,
        S_WAIT2
    } state_t;

    state_t             r_state;
    state_t             w_nxt_state;
    logic [GW-1:0]      r_gap_cnt;
    logic [1:0]         r_rr;
    logic [15:0]        r_cmd;
    logic               r_wrt;
    logic               r_conv_done;
    logic [3:0][11:0]   r_res;
    logic               w_store;
    logic               w_restart;
    logic               w_unused;

    // Channel command word for a round-robin slot.
    function automatic logic [15:0] chan_cmd(input logic [1:0] rr);
        logic [2:0] ch;
        case (rr)
            2'd0:    ch = CH_LFT;
            2'd1:    ch = CH_RGHT;
            2'd2:    ch = CH_STEER;
            default: ch = CH_BATT;
        endcase
        return {2'b00, ch, 11'h000};
    endfunction

    // Completion of the result transaction: the only point a result is written.
    assign w_store = (r_state == S_WAIT2) && i_done;

`ifdef A2D_NXT_QUEUE_EN
    logic r_pend;

    // One-deep request memory. A request arriving on the very cycle the
    // result lands also chains directly, so it never needs to be latched.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pend <= 1'b0;
        end else if (w_store) begin
            r_pend <= 1'b0;
        end else if (i_nxt && (r_state != S_IDLE)) begin
            r_pend <= 1'b1;
        end
    end

    assign w_restart = w_store && (r_pend || i_nxt);
`else
    assign w_restart = 1'b0;
`endif

    // State register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_nxt_state;
        end
    end

    // Next-state logic; done outside WAIT1/WAIT2 falls through untouched.
    always_comb begin
        w_nxt_state = r_state;
        case (r_state)
            S_IDLE:  if (i_nxt) w_nxt_state = S_CMD;
            S_CMD:   w_nxt_state = S_WAIT1;
            S_WAIT1: if (i_done) w_nxt_state = S_GAP;
            S_GAP:   if (r_gap_cnt == GAP_LAST) w_nxt_state = S_RD;
            S_RD:    w_nxt_state = S_WAIT2;
            S_WAIT2: if (i_done) w_nxt_state = w_restart ? S_CMD : S_IDLE;
            default: w_nxt_state = S_IDLE;
        endcase
    end

    // GAP dwell counter; zero whenever GAP is not active so each entry
    // starts a fresh count.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_gap_cnt <= '0;
        end else if (r_state == S_GAP) begin
            r_gap_cnt <= r_gap_cnt + GW'(1);
        end else begin
            r_gap_cnt <= '0;
        end
    end

    // Datapath and registered handshake outputs
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wrt       <= 1'b0;
            r_cmd       <= 16'h0000;
            r_rr        <= 2'd0;
            r_conv_done <= 1'b0;
            r_res       <= '0;
        end else begin
            // wrt is registered off the next state so it coincides with the
            // single cycle spent in CMD or RD.
            r_wrt       <= (w_nxt_state == S_CMD) || (w_nxt_state == S_RD);
            r_conv_done <= w_store;

            // The same command stays on o_cmd for both transactions.
            // A chained conversion targets the slot rr is advancing to.
            if ((r_state == S_IDLE) && i_nxt) begin
                r_cmd <= chan_cmd(r_rr);
            end else if (w_restart) begin
                r_cmd <= chan_cmd(r_rr + 2'd1);
            end

            if (w_store) begin
                r_res[r_rr] <= i_rd_data[11:0];
                r_rr        <= r_rr + 2'd1;
            end
        end
    end

    // Upper nibble of the ADC frame carries no data.
    assign w_unused    = ^i_rd_data[15:12];

    assign o_wrt       = r_wrt;
    assign o_cmd       = r_cmd;
    assign o_busy      = (r_state != S_IDLE);
    assign o_conv_done = r_conv_done;
    assign o_lft_ld    = r_res[0];
    assign o_rght_ld   = r_res[1];
    assign o_steer_pot = r_res[2];
    assign o_batt      = r_res[3];

endmodule
